// File: rtl/wb_lsu_pkg.sv
// Shared constants for the Wishbone load/store master: funct3 codes, FSM states and
// the default bus timeout.
package wb_lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int unsigned TimeoutCyclesDefault = 255;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBus  = 2'd1,
    StResp = 2'd2
  } state_e;

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane logic: store steering and legality check on the request side,
// load extraction and sign/zero extension on the response side.
module lsu_lane_align
  import wb_lsu_pkg::*;
(
  input  logic        we_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  output logic [3:0]  sel_o,
  output logic [31:0] wdat_o,
  output logic        illegal_o,
  input  logic [2:0]  ld_funct3_i,
  input  logic [1:0]  ld_addr_lo_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] ld_data_o
);

  logic        bad_f3;
  logic        misalign;
  logic [31:0] shifted;

  always_comb begin
    sel_o    = 4'b0000;
    wdat_o   = '0;
    bad_f3   = 1'b0;
    misalign = 1'b0;
    unique case (funct3_i[1:0])
      2'b00: begin
        sel_o  = 4'b0001 << addr_lo_i;
        wdat_o = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        sel_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdat_o   = {2{wdata_i[15:0]}};
        misalign = addr_lo_i[0];
      end
      2'b10: begin
        sel_o    = 4'b1111;
        wdat_o   = wdata_i;
        misalign = |addr_lo_i;
      end
      default: bad_f3 = 1'b1;
    endcase
    // Stores have no unsigned variants; loads have no 110 encoding.
    if (we_i && funct3_i[2]) bad_f3 = 1'b1;
    if (!we_i && funct3_i == 3'b110) bad_f3 = 1'b1;
    illegal_o = bad_f3 | misalign;
  end

  always_comb begin
    shifted = rdata_i >> {ld_addr_lo_i, 3'b000};
    unique case (ld_funct3_i)
      F3_B:    ld_data_o = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   ld_data_o = {24'b0, shifted[7:0]};
      F3_H:    ld_data_o = {{16{shifted[15]}}, shifted[15:0]};
      F3_HU:   ld_data_o = {16'b0, shifted[15:0]};
      default: ld_data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/wb_lsu_master.sv
// Wishbone B4 classic master running one load/store per request, with registered bus and
// response outputs and an optional no-response timeout.
module wb_lsu_master
  import wb_lsu_pkg::*;
#(
  parameter int unsigned DATA_LENGTH    = 32,
  parameter int unsigned ADDR_LENGTH    = 32,
  parameter int unsigned TIMEOUT_CYCLES = TimeoutCyclesDefault
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [ADDR_LENGTH-1:0] req_addr,
  input  logic [2:0]             req_funct3,
  input  logic [DATA_LENGTH-1:0] req_wdata,
  output logic                   rsp_valid,
  output logic [DATA_LENGTH-1:0] rsp_rdata,
  output logic                   rsp_err,
  output logic                   wb_cyc_o,
  output logic                   wb_stb_o,
  output logic                   wb_we_o,
  output logic [ADDR_LENGTH-1:0] wb_adr_o,
  output logic [3:0]             wb_sel_o,
  output logic [DATA_LENGTH-1:0] wb_dat_o,
  input  logic [DATA_LENGTH-1:0] wb_dat_i,
  input  logic                   wb_ack_i,
  input  logic                   wb_err_i
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  state_e                 state_q;
  logic                   ready_q, rsp_valid_q, rsp_err_q, cyc_q, we_q;
  logic [DATA_LENGTH-1:0] rsp_rdata_q, dat_q;
  logic [ADDR_LENGTH-1:0] adr_q;
  logic [3:0]             sel_q;
  logic [2:0]             f3_q;
  logic [1:0]             addr_lo_q;
  logic [CntW-1:0]        cnt_q;

  logic [3:0]  sel;
  logic [31:0] wdat, ld_data;
  logic        illegal, timeout_hit;

  lsu_lane_align u_lane_align (
    .we_i        (req_we),
    .funct3_i    (req_funct3),
    .addr_lo_i   (req_addr[1:0]),
    .wdata_i     (req_wdata),
    .sel_o       (sel),
    .wdat_o      (wdat),
    .illegal_o   (illegal),
    .ld_funct3_i (f3_q),
    .ld_addr_lo_i(addr_lo_q),
    .rdata_i     (wb_dat_i),
    .ld_data_o   (ld_data)
  );

  assign timeout_hit = (TIMEOUT_CYCLES != 0) &&
                       ((cnt_q + CntW'(1)) == CntW'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      sel_q       <= '0;
      dat_q       <= '0;
      f3_q        <= '0;
      addr_lo_q   <= '0;
      cnt_q       <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            ready_q <= 1'b0;
            if (illegal) begin
              state_q     <= StResp;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= '0;
            end else begin
              state_q   <= StBus;
              cyc_q     <= 1'b1;
              we_q      <= req_we;
              adr_q     <= {req_addr[ADDR_LENGTH-1:2], 2'b00};
              sel_q     <= sel;
              dat_q     <= req_we ? wdat : '0;
              f3_q      <= req_funct3;
              addr_lo_q <= req_addr[1:0];
              cnt_q     <= '0;
            end
          end
        end
        StBus: begin
          if (wb_err_i || wb_ack_i || timeout_hit) begin
            state_q     <= StResp;
            cyc_q       <= 1'b0;
            rsp_valid_q <= 1'b1;
            // ERR wins over a simultaneous ACK; no ACK at all means timeout.
            rsp_err_q   <= wb_err_i || !wb_ack_i;
            rsp_rdata_q <= (wb_ack_i && !wb_err_i && !we_q) ? ld_data : '0;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StResp: begin
          state_q     <= StIdle;
          rsp_valid_q <= 1'b0;
          ready_q     <= 1'b1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign req_ready = ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign wb_cyc_o  = cyc_q;
  assign wb_stb_o  = cyc_q;
  assign wb_we_o   = we_q;
  assign wb_adr_o  = adr_q;
  assign wb_sel_o  = sel_q;
  assign wb_dat_o  = dat_q;

endmodule

// File: tb/tb_wb_lsu_master.sv
// Self-checking bench for wb_lsu_master: directed cases, async reset during a bus cycle,
// and randomized accesses against an arithmetic reference model.
module tb_wb_lsu_master;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0, req_we = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [2:0]  req_funct3 = '0;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0] wb_adr_o, wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_i = '0;
  logic        wb_ack_i = 1'b0, wb_err_i = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  wb_lsu_master #(.DATA_LENGTH(32), .ADDR_LENGTH(32), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
    .req_funct3(req_funct3), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_adr_o(wb_adr_o),
    .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
  );

  always #5 clk = ~clk;

  // Observations of the most recent transaction.
  logic [31:0] o_adr, o_dat, o_rdata;
  logic [3:0]  o_sel;
  logic        o_we, o_err;
  int          o_cycles, o_lat;
  bit          o_stable, o_ready_bad, o_pulse_ok;

  // term: 0 ack, 1 err, 2 ack+err, 3 no response. Ack/err comes on bus cycle delay+1.
  task automatic bus_txn(input logic we, input logic [31:0] addr, input logic [2:0] f3,
                         input logic [31:0] wdata, input int delay, input logic [31:0] sdata,
                         input int term, input bit hold);
    bit done = 0;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_funct3 = f3; req_wdata = wdata;
    wb_ack_i = 1'($urandom); wb_err_i = 1'($urandom);
    o_cycles = 0; o_lat = -1; o_stable = 1; o_ready_bad = 0; o_pulse_ok = 0;
    o_rdata = 'x; o_err = 1'bx; o_adr = 'x; o_sel = 'x; o_dat = 'x; o_we = 1'bx;
    @(posedge clk); #1;
    req_valid = hold;
    if (hold) begin
      req_addr = $urandom; req_funct3 = 3'($urandom); req_we = 1'($urandom);
      req_wdata = $urandom;
    end
    wb_dat_i = sdata;
    for (int k = 1; k <= 30 && !done; k++) begin
      if (req_ready) o_ready_bad = 1;
      if (rsp_valid) begin
        o_lat = k; o_rdata = rsp_rdata; o_err = rsp_err; done = 1;
        req_valid = 1'b0;
        wb_ack_i = 1'($urandom); wb_err_i = 1'($urandom);
        @(posedge clk); #1;
        o_pulse_ok = !rsp_valid && req_ready;
        wb_ack_i = 1'b0; wb_err_i = 1'b0;
      end else begin
        if (wb_cyc_o) begin
          if (o_cycles == 0) begin
            o_adr = wb_adr_o; o_sel = wb_sel_o; o_dat = wb_dat_o; o_we = wb_we_o;
          end else if ({wb_adr_o, wb_sel_o, wb_dat_o, wb_we_o} !== {o_adr, o_sel, o_dat, o_we})
            o_stable = 0;
          if (wb_stb_o !== 1'b1) o_stable = 0;
          o_cycles++;
          wb_ack_i = (o_cycles == delay + 1) && (term == 0 || term == 2);
          wb_err_i = (o_cycles == delay + 1) && (term == 1 || term == 2);
        end else begin
          wb_ack_i = 1'b0; wb_err_i = 1'b0;
        end
        @(posedge clk); #1;
      end
    end
    req_valid = 1'b0;
  endtask

  // Reference model derived from the access rules with plain arithmetic.
  task automatic ref_model(input logic we, input logic [31:0] addr, input logic [2:0] f3,
                           input logic [31:0] wdata, input int delay, input logic [31:0] sdata,
                           input int term, output bit legal, output logic [31:0] e_adr,
                           output logic [3:0] e_sel, output logic [31:0] e_dat,
                           output logic [31:0] e_rdata, output logic e_err,
                           output int e_cycles, output int e_lat);
    int     size, off;
    longint v;
    off  = int'(addr % 4);
    size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : (f3[1:0] == 2'd2) ? 4 : 0;
    legal = 0;
    if (size != 0 && (we ? !f3[2] : f3 != 3'b110)) legal = (addr % size) == 0;
    e_adr = addr & 32'hFFFF_FFFC;
    e_sel = 4'(((1 << size) - 1) << off);
    e_dat = (size == 1) ? (wdata & 32'hFF) * 32'h0101_0101 :
            (size == 2) ? (wdata & 32'hFFFF) * 32'h0001_0001 : wdata;
    v = longint'((sdata >> (8 * off)) & ((64'd1 << (8 * size)) - 1));
    if (!f3[2] && size < 4 && size > 0 && v >= longint'(64'd1 << (8 * size - 1)))
      v = v - longint'(64'd1 << (8 * size));
    e_err    = !legal || term != 0;
    e_rdata  = (e_err || we) ? 32'd0 : 32'(v);
    e_cycles = !legal ? 0 : (term == 3) ? 4 : delay + 1;
    e_lat    = !legal ? 1 : e_cycles + 1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_errors++; $display("FAIL reset_ready: got %b want 1", req_ready);
    end
    n_checks++;
    if ({rsp_valid, rsp_err, wb_cyc_o, wb_stb_o, wb_we_o} !== 5'b0) begin
      n_errors++;
      $display("FAIL reset_ctrl: got %b want 00000",
               {rsp_valid, rsp_err, wb_cyc_o, wb_stb_o, wb_we_o});
    end
    n_checks++;
    if ({rsp_rdata, wb_adr_o, wb_dat_o, wb_sel_o} !== 100'b0) begin
      n_errors++;
      $display("FAIL reset_data: got %h want 0", {rsp_rdata, wb_adr_o, wb_dat_o, wb_sel_o});
    end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  typedef struct {
    string       name;
    logic        we;
    logic [31:0] addr;
    logic [2:0]  f3;
    logic [31:0] wdata;
    int          delay;
    logic [31:0] sdata;
    int          term;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [31:0] rdata;
    logic        err;
    int          cycles;
    int          lat;
  } vec_t;

  task automatic test_directed();
    vec_t v[10];
    v[0] = '{"lw",     0, 32'h100, 3'b010, 0,            0, 32'hDEADBEEF, 0,
             4'b1111, 32'h100, 0, 32'hDEADBEEF, 0, 1, 2};
    v[1] = '{"lb",     0, 32'h103, 3'b000, 0,            0, 32'h80123456, 0,
             4'b1000, 32'h100, 0, 32'hFFFFFF80, 0, 1, 2};
    v[2] = '{"lbu",    0, 32'h103, 3'b100, 0,            0, 32'h80123456, 0,
             4'b1000, 32'h100, 0, 32'h00000080, 0, 1, 2};
    v[3] = '{"sh",     1, 32'h202, 3'b001, 32'h0000ABCD, 3, 32'h12345678, 0,
             4'b1100, 32'h200, 32'hABCDABCD, 0, 0, 4, 5};
    v[4] = '{"sb",     1, 32'h301, 3'b000, 32'h12345678, 1, 0, 0,
             4'b0010, 32'h300, 32'h78787878, 0, 0, 2, 3};
    v[5] = '{"lh_neg", 0, 32'h402, 3'b001, 0,            0, 32'h8001FFFF, 0,
             4'b1100, 32'h400, 0, 32'hFFFF8001, 0, 1, 2};
    v[6] = '{"lw_mis", 0, 32'h101, 3'b010, 0,            0, 0, 0,
             4'b0000, 32'h0, 0, 0, 1, 0, 1};
    v[7] = '{"ld_011", 0, 32'h100, 3'b011, 0,            0, 0, 0,
             4'b0000, 32'h0, 0, 0, 1, 0, 1};
    v[8] = '{"tmo",    0, 32'h100, 3'b010, 0,            0, 32'hFFFFFFFF, 3,
             4'b1111, 32'h100, 0, 0, 1, 4, 5};
    v[9] = '{"ackerr", 0, 32'h104, 3'b010, 0,            1, 32'h55555555, 2,
             4'b1111, 32'h104, 0, 0, 1, 2, 3};
    foreach (v[i]) begin
      bus_txn(v[i].we, v[i].addr, v[i].f3, v[i].wdata, v[i].delay, v[i].sdata, v[i].term, 0);
      n_checks++;
      if (o_lat !== v[i].lat) begin
        n_errors++; $display("FAIL %s latency: got %0d want %0d", v[i].name, o_lat, v[i].lat);
      end
      n_checks++;
      if (o_cycles !== v[i].cycles) begin
        n_errors++;
        $display("FAIL %s cyc_cycles: got %0d want %0d", v[i].name, o_cycles, v[i].cycles);
      end
      n_checks++;
      if ({o_err, o_rdata} !== {v[i].err, v[i].rdata}) begin
        n_errors++;
        $display("FAIL %s rsp: got err=%b rdata=%h want err=%b rdata=%h",
                 v[i].name, o_err, o_rdata, v[i].err, v[i].rdata);
      end
      n_checks++;
      if (!o_stable || o_ready_bad || !o_pulse_ok) begin
        n_errors++;
        $display("FAIL %s handshake: got stable=%b ready_busy=%b pulse_ok=%b want 1 0 1",
                 v[i].name, o_stable, o_ready_bad, o_pulse_ok);
      end
      if (v[i].cycles > 0) begin
        n_checks++;
        if ({o_sel, o_adr, o_we} !== {v[i].sel, v[i].adr, v[i].we} ||
            (v[i].we && o_dat !== v[i].dat)) begin
          n_errors++;
          $display("FAIL %s bus: got sel=%b adr=%h we=%b dat=%h want sel=%b adr=%h we=%b dat=%h",
                   v[i].name, o_sel, o_adr, o_we, o_dat, v[i].sel, v[i].adr, v[i].we, v[i].dat);
        end
      end
    end
  endtask

  task automatic test_reset_mid_bus();
    bit seen = 0;
    bit legal; logic [31:0] e_adr, e_dat, e_rdata; logic [3:0] e_sel; logic e_err;
    int e_cycles, e_lat;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h300; req_funct3 = 3'b010;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (wb_cyc_o !== 1'b1) begin
      n_errors++; $display("FAIL rst_mid_pre: got cyc=%b want 1", wb_cyc_o);
    end
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if ({wb_cyc_o, wb_stb_o, req_ready} !== 3'b001) begin
      n_errors++;
      $display("FAIL rst_mid_async: got cyc/stb/ready=%b want 001",
               {wb_cyc_o, wb_stb_o, req_ready});
    end
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (6) begin
      if (rsp_valid) seen = 1;
      @(posedge clk); #1;
    end
    n_checks++;
    if (seen) begin
      n_errors++; $display("FAIL rst_mid_norsp: got rsp_valid=1 want 0");
    end
    bus_txn(0, 32'h308, 3'b010, 0, 0, 32'hCAFEF00D, 0, 0);
    ref_model(0, 32'h308, 3'b010, 0, 0, 32'hCAFEF00D, 0, legal, e_adr, e_sel, e_dat, e_rdata,
              e_err, e_cycles, e_lat);
    n_checks++;
    if ({o_lat, o_err, o_rdata, o_adr} !== {e_lat, e_err, e_rdata, e_adr}) begin
      n_errors++;
      $display("FAIL rst_mid_after: got lat=%0d err=%b rdata=%h adr=%h want %0d %b %h %h",
               o_lat, o_err, o_rdata, o_adr, e_lat, e_err, e_rdata, e_adr);
    end
  endtask

  task automatic test_random();
    bit legal; logic [31:0] e_adr, e_dat, e_rdata; logic [3:0] e_sel; logic e_err;
    int e_cycles, e_lat;
    logic we; logic [31:0] addr, wdata, sdata; logic [2:0] f3; int delay, term, r;
    for (int i = 0; i < 150; i++) begin
      we    = 1'($urandom);
      addr  = {$urandom_range(0, 255), 2'b00} | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) addr[1:0] = 2'b00;
      f3    = 3'($urandom);
      if (we && $urandom_range(0, 3) != 0) f3[2] = 1'b0;
      wdata = $urandom;
      sdata = $urandom;
      delay = $urandom_range(0, 3);
      r     = $urandom_range(0, 15);
      term  = (r < 11) ? 0 : (r < 13) ? 1 : (r < 15) ? 2 : 3;
      bus_txn(we, addr, f3, wdata, delay, sdata, term, 1'($urandom));
      ref_model(we, addr, f3, wdata, delay, sdata, term, legal, e_adr, e_sel, e_dat, e_rdata,
                e_err, e_cycles, e_lat);
      n_checks++;
      if ({o_lat, o_cycles} !== {e_lat, e_cycles}) begin
        n_errors++;
        $display("FAIL rnd%0d timing: got lat=%0d cycles=%0d want lat=%0d cycles=%0d",
                 i, o_lat, o_cycles, e_lat, e_cycles);
      end
      n_checks++;
      if ({o_err, o_rdata} !== {e_err, e_rdata}) begin
        n_errors++;
        $display("FAIL rnd%0d rsp: got err=%b rdata=%h want err=%b rdata=%h (we=%b a=%h f3=%b)",
                 i, o_err, o_rdata, e_err, e_rdata, we, addr, f3);
      end
      n_checks++;
      if (!o_stable || o_ready_bad || !o_pulse_ok) begin
        n_errors++;
        $display("FAIL rnd%0d handshake: got stable=%b ready_busy=%b pulse_ok=%b want 1 0 1",
                 i, o_stable, o_ready_bad, o_pulse_ok);
      end
      if (legal) begin
        n_checks++;
        if ({o_sel, o_adr, o_we} !== {e_sel, e_adr, we} || (we && o_dat !== e_dat)) begin
          n_errors++;
          $display("FAIL rnd%0d bus: got sel=%b adr=%h we=%b dat=%h want sel=%b adr=%h dat=%h",
                   i, o_sel, o_adr, o_we, o_dat, e_sel, e_adr, e_dat);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_reset_mid_bus();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
